// File: rtl/rss_sched.sv
// rss_sched: entry-credit allocation and round-robin issue selection for the
// store/load reservation-station buffer. Allocation is all-or-nothing across
// three dispatch slots; issue grants up to ISSUE_MAX of four ready ports.
module rss_sched #(
  parameter int DEPTH     = 32,
  parameter int CNT_W     = 6,
  parameter int ISSUE_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       alloc_req,
  output logic             newRsSelect0,
  output logic             newRsSelect1,
  output logic             newRsSelect2,
  output logic             alloc_stall,
  input  logic             portReady0,
  input  logic             portReady1,
  input  logic             portReady2,
  input  logic             portReady3,
  input  logic [3:0]       fu_busy,
  output logic             outRsSelect0,
  output logic             outRsSelect1,
  output logic             outRsSelect2,
  output logic             outRsSelect3,
  output logic [CNT_W-1:0] free_cnt,
  output logic             credit_err
);

  // Two extra bits hold the credit sum: one for headroom above DEPTH, one as a sign.
  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

  logic [CNT_W-1:0] free;
  logic [1:0]       rr;
  logic             errReg;

  logic [1:0]       nreq;
  logic             allocOk;
  logic [1:0]       nalloc;
  logic [2:0]       newSel;
  logic             stallOut;

  logic [3:0]       portReady;
  logic [3:0]       elig;
  logic [3:0]       grantVec;
  logic [2:0]       nissue;
  logic [1:0]       lastPort;
  logic [1:0]       scanPort;

  logic [SUM_W-1:0] creditSum;
  logic [CNT_W-1:0] freeNext;
  logic             satErr;

  assign nreq      = 2'(alloc_req[0]) + 2'(alloc_req[1]) + 2'(alloc_req[2]);
  assign allocOk   = (CNT_W'(nreq) <= free);
  assign portReady = {portReady3, portReady2, portReady1, portReady0};
  assign elig      = portReady & ~fu_busy & {4{~stall}};

  // All-or-nothing allocation against the credits registered last cycle.
  always_comb begin
    newSel   = 3'b000;
    nalloc   = 2'd0;
    stallOut = 1'b0;
    if (allocOk) begin
      newSel = alloc_req;
      nalloc = nreq;
    end else begin
      stallOut = (nreq != 2'd0);
    end
  end

  // Scan ports from rr with wraparound and take the first ISSUE_MAX eligible ones.
  always_comb begin
    grantVec = 4'b0000;
    nissue   = 3'd0;
    lastPort = rr;
    scanPort = rr;
    for (int k = 0; k < 4; k++) begin
      scanPort = rr + 2'(k);
      if (elig[scanPort] && (nissue < 3'(ISSUE_MAX))) begin
        grantVec[scanPort] = 1'b1;
        nissue             = nissue + 3'd1;
        lastPort           = scanPort;
      end
    end
  end

  // Next credit count with saturation to 0..DEPTH and an error flag when clipped.
  always_comb begin
    creditSum = SUM_W'(free) - SUM_W'(nalloc) + SUM_W'(nissue);
    freeNext  = creditSum[CNT_W-1:0];
    satErr    = 1'b0;
    if (creditSum[SUM_W-1]) begin
      freeNext = '0;
      satErr   = 1'b1;
    end else if (creditSum > DEPTH_S) begin
      freeNext = DEPTH_C;
      satErr   = 1'b1;
    end
  end

  // Credit, pointer and sticky error state; reset beats flush, flush leaves rr alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      free   <= DEPTH_C;
      rr     <= 2'd0;
      errReg <= 1'b0;
    end else if (flush) begin
      free <= DEPTH_C;
    end else begin
      free <= freeNext;
      if (nissue != 3'd0) begin
        rr <= lastPort + 2'd1;
      end
      if (satErr) begin
        errReg <= 1'b1;
      end
    end
  end

  assign newRsSelect0 = newSel[0] & ~rst;
  assign newRsSelect1 = newSel[1] & ~rst;
  assign newRsSelect2 = newSel[2] & ~rst;
  assign alloc_stall  = stallOut & ~rst;
  assign outRsSelect0 = grantVec[0] & ~rst;
  assign outRsSelect1 = grantVec[1] & ~rst;
  assign outRsSelect2 = grantVec[2] & ~rst;
  assign outRsSelect3 = grantVec[3] & ~rst;
  assign free_cnt     = free;
  assign credit_err   = errReg;

endmodule

// File: tb/tb_rss_sched.sv
// tb_rss_sched: directed stimulus for rss_sched, checked every cycle against a
// spec-level model of credits and the round-robin pointer, plus literal checkpoints.
module tb_rss_sched;

  localparam int DEPTH     = 32;
  localparam int CNT_W     = 6;
  localparam int ISSUE_MAX = 2;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             flush;
  logic [2:0]       allocReq;
  logic             newRsSelect0, newRsSelect1, newRsSelect2;
  logic             allocStall;
  logic [3:0]       portReady;
  logic [3:0]       fuBusy;
  logic             outRsSelect0, outRsSelect1, outRsSelect2, outRsSelect3;
  logic [CNT_W-1:0] freeCnt;
  logic             creditErr;

  logic [2:0]       newVec;
  logic [3:0]       outVec;

  int errCount   = 0;
  int checkCount = 0;

  // Model state: credits, pointer and sticky error as plain integers.
  int mFree = DEPTH;
  int mRr   = 0;
  int mErr  = 0;

  assign newVec = {newRsSelect2, newRsSelect1, newRsSelect0};
  assign outVec = {outRsSelect3, outRsSelect2, outRsSelect1, outRsSelect0};

  rss_sched #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .ISSUE_MAX(ISSUE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .alloc_req(allocReq),
    .newRsSelect0(newRsSelect0),
    .newRsSelect1(newRsSelect1),
    .newRsSelect2(newRsSelect2),
    .alloc_stall(allocStall),
    .portReady0(portReady[0]),
    .portReady1(portReady[1]),
    .portReady2(portReady[2]),
    .portReady3(portReady[3]),
    .fu_busy(fuBusy),
    .outRsSelect0(outRsSelect0),
    .outRsSelect1(outRsSelect1),
    .outRsSelect2(outRsSelect2),
    .outRsSelect3(outRsSelect3),
    .free_cnt(freeCnt),
    .credit_err(creditErr)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs after the edge, then at the falling edge compare the
  // DUT with the model and advance the model to the state after the next edge.
  task automatic applyStimulus(input logic r, input logic st, input logic fl,
                               input logic [2:0] req, input logic [3:0] rdy,
                               input logic [3:0] busy);
    int nreq, nalloc, nissue, lastP, p, v;
    logic [2:0] expNew;
    logic [3:0] expOut;
    logic       expStall;
    @(posedge clk);
    #1;
    rst      = r;
    stall    = st;
    flush    = fl;
    allocReq = req;
    portReady = rdy;
    fuBusy   = busy;
    @(negedge clk);
    nreq     = $countones(req);
    nalloc   = 0;
    nissue   = 0;
    lastP    = 0;
    expNew   = 3'b000;
    expOut   = 4'b0000;
    expStall = 1'b0;
    if (!r) begin
      if (nreq <= mFree) begin
        expNew = req;
        nalloc = nreq;
      end else begin
        expStall = (nreq != 0);
      end
      for (int k = 0; k < 4; k++) begin
        p = (mRr + k) % 4;
        if (rdy[p] && !busy[p] && !st && nissue < ISSUE_MAX) begin
          expOut[p] = 1'b1;
          nissue++;
          lastP = p;
        end
      end
    end
    checkOutput("model.newRsSelect", 8'(newVec), 8'(expNew));
    checkOutput("model.alloc_stall", 8'(allocStall), 8'(expStall));
    checkOutput("model.outRsSelect", 8'(outVec), 8'(expOut));
    checkOutput("model.free_cnt", 8'(freeCnt), 8'(mFree));
    checkOutput("model.credit_err", 8'(creditErr), 8'(mErr));
    if (r) begin
      mFree = DEPTH;
      mRr   = 0;
      mErr  = 0;
    end else if (fl) begin
      mFree = DEPTH;
    end else begin
      v = mFree - nalloc + nissue;
      if (v > DEPTH) begin
        v    = DEPTH;
        mErr = 1;
      end else if (v < 0) begin
        v    = 0;
        mErr = 1;
      end
      mFree = v;
      if (nissue > 0) mRr = (lastP + 1) % 4;
    end
  endtask

  // Directed scenario sequence with hand-computed checkpoints.
  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    allocReq = 3'b111; portReady = 4'b1111; fuBusy = 4'b0000;

    // Reset for two cycles with active requests that must be masked.
    applyStimulus(1, 0, 0, 3'b111, 4'b1111, 4'b0000);
    applyStimulus(1, 0, 0, 3'b111, 4'b1111, 4'b0000);
    checkOutput("reset.free_cnt", 8'(freeCnt), 8'd32);
    checkOutput("reset.newRsSelect", 8'(newVec), 8'd0);
    checkOutput("reset.outRsSelect", 8'(outVec), 8'd0);
    checkOutput("reset.alloc_stall", 8'(allocStall), 8'd0);
    checkOutput("reset.credit_err", 8'(creditErr), 8'd0);

    // Fill: ten triple allocations, then a stall at free=2, then a double.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 3'b111, 4'b0000, 4'b0000);
      if (i == 0) checkOutput("fill.first_grant", 8'(newVec), 8'b111);
    end
    applyStimulus(0, 0, 0, 3'b111, 4'b0000, 4'b0000);
    checkOutput("fill.free_at_11", 8'(freeCnt), 8'd2);
    checkOutput("fill.alloc_stall", 8'(allocStall), 8'd1);
    checkOutput("fill.no_grant", 8'(newVec), 8'd0);
    applyStimulus(0, 0, 0, 3'b011, 4'b0000, 4'b0000);
    checkOutput("fill.double_grant", 8'(newVec), 8'b011);

    // Round-robin drain back to full.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 3'b000, 4'b1111, 4'b0000);
      if (i == 0) begin
        checkOutput("rr.free_empty", 8'(freeCnt), 8'd0);
        checkOutput("rr.grant01", 8'(outVec), 8'b0011);
      end
      if (i == 1) checkOutput("rr.grant23", 8'(outVec), 8'b1100);
      if (i == 2) begin
        checkOutput("rr.grant01_again", 8'(outVec), 8'b0011);
        checkOutput("rr.free_4", 8'(freeCnt), 8'd4);
      end
    end
    applyStimulus(0, 0, 0, 3'b111, 4'b0000, 4'b0000);
    checkOutput("rr.full", 8'(freeCnt), 8'd32);
    applyStimulus(0, 0, 0, 3'b111, 4'b0000, 4'b0000);

    // Busy masking, then stall blocking issue but not allocation.
    applyStimulus(0, 0, 0, 3'b000, 4'b1111, 4'b0101);
    checkOutput("busy.grant13", 8'(outVec), 8'b1010);
    applyStimulus(0, 1, 0, 3'b001, 4'b1111, 4'b0000);
    checkOutput("stall.no_issue", 8'(outVec), 8'd0);
    checkOutput("stall.alloc_ok", 8'(newVec), 8'b001);
    applyStimulus(0, 0, 0, 3'b000, 4'b1111, 4'b0000);
    checkOutput("stall.rr_held", 8'(outVec), 8'b0011);

    // Drain credits to zero, then simultaneous alloc and issue.
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 3'b111, 4'b0000, 4'b0000);
    applyStimulus(0, 0, 0, 3'b011, 4'b0000, 4'b0000);
    applyStimulus(0, 0, 0, 3'b001, 4'b0101, 4'b0000);
    checkOutput("simul.free0", 8'(freeCnt), 8'd0);
    checkOutput("simul.alloc_stall", 8'(allocStall), 8'd1);
    checkOutput("simul.grant02", 8'(outVec), 8'b0101);
    applyStimulus(0, 0, 0, 3'b001, 4'b0000, 4'b0000);
    checkOutput("simul.free2", 8'(freeCnt), 8'd2);
    checkOutput("simul.retry_grant", 8'(newVec), 8'b001);
    applyStimulus(0, 0, 0, 3'b000, 4'b1111, 4'b0000);
    checkOutput("simul.free1", 8'(freeCnt), 8'd1);
    checkOutput("simul.grant12", 8'(outVec), 8'b0110);
    applyStimulus(0, 0, 0, 3'b000, 4'b1111, 4'b0000);

    // Flush at free=5 with allocation and an issue; rr must be unchanged.
    applyStimulus(0, 0, 1, 3'b111, 4'b0001, 4'b0000);
    checkOutput("flush.free5", 8'(freeCnt), 8'd5);
    checkOutput("flush.alloc", 8'(newVec), 8'b111);
    applyStimulus(0, 0, 0, 3'b111, 4'b1111, 4'b0000);
    checkOutput("flush.restored", 8'(freeCnt), 8'd32);
    checkOutput("flush.rr_held", 8'(outVec), 8'b0110);
    applyStimulus(1, 0, 1, 3'b111, 4'b1111, 4'b0000);
    checkOutput("rstflush.no_grant", 8'(newVec), 8'd0);
    checkOutput("rstflush.no_issue", 8'(outVec), 8'd0);

    // Overflow at full credit sets the sticky error.
    applyStimulus(0, 0, 0, 3'b000, 4'b0001, 4'b0000);
    checkOutput("err.before", 8'(creditErr), 8'd0);
    checkOutput("err.grant0", 8'(outVec), 8'b0001);
    applyStimulus(0, 0, 0, 3'b000, 4'b0000, 4'b0000);
    checkOutput("err.saturated", 8'(freeCnt), 8'd32);
    checkOutput("err.set", 8'(creditErr), 8'd1);
    applyStimulus(0, 0, 0, 3'b111, 4'b0000, 4'b0000);
    applyStimulus(0, 0, 1, 3'b000, 4'b0011, 4'b0000);
    applyStimulus(0, 0, 0, 3'b000, 4'b0000, 4'b0000);
    checkOutput("err.sticky", 8'(creditErr), 8'd1);
    applyStimulus(1, 0, 0, 3'b000, 4'b0000, 4'b0000);
    applyStimulus(0, 0, 0, 3'b000, 4'b0000, 4'b0000);
    checkOutput("err.cleared", 8'(creditErr), 8'd0);
    checkOutput("err.free_reset", 8'(freeCnt), 8'd32);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rss_sched.md
# rss_sched

Allocation and issue controller for the store/load reservation-station buffer. It keeps an entry-credit count for the buffer and grants up to three new ops per cycle, all-or-nothing. Each cycle it picks at most two of the buffer's four ready output ports (AGU0, data1, AGU2, data3) using a rotating round-robin pointer. It sits between rename/dispatch and the buffer, and drives the buffer's `newRsSelectN` and `outRsSelectN` inputs.

## Interface
- `DEPTH`, 32: buffer entries; credit counter reset value.
- `CNT_W`, 6: credit counter width; must satisfy 2^CNT_W > DEPTH.
- `ISSUE_MAX`, 2: maximum port grants per cycle (1..4).

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  back-end stall; no issue grants this cycle.
- `flush`  in  1  buffer emptied this cycle; credits restored next cycle.
- `alloc_req`  in  3  bit i = dispatch slot i wants an entry.
- `newRsSelect0..2`  out  1 each  slot i granted an entry (to buffer).
- `alloc_stall`  out  1  request not satisfiable; no slot granted.
- `portReady0..3`  in  1 each  buffer has a ready entry for port n.
- `fu_busy`  in  4  bit n = FU behind port n cannot accept.
- `outRsSelect0..3`  out  1 each  issue grant for port n (to buffer).
- `free_cnt`  out  CNT_W  registered credit count.
- `credit_err`  out  1  sticky; the credit count would have left 0..DEPTH.

## Operation
- Credit register `free` is reset to DEPTH.
- `nreq` = popcount(alloc_req), range 0..3.
- Allocation: if `nreq` <= `free`, then `newRsSelect[i]` = `alloc_req[i]`, `alloc_stall` = 0 and `nalloc` = `nreq`.
- Otherwise all `newRsSelect` = 0, `alloc_stall` = (`nreq` != 0) and `nalloc` = 0. No partial grants.
- `flush` does not block allocation in the same cycle.
- Issue eligibility: `elig[n]` = `portReady[n]` & ~`fu_busy[n]` & ~`stall`.
- Issue arbitration: scan ports starting at pointer `rr` (2 bits) and wrapping n = rr, rr+1, …, rr+3 mod 4.
- Grant the first `ISSUE_MAX` eligible ports found. `nissue` = number of grants.
- Pointer update: if `nissue` > 0, `rr` <= (last granted port + 1) mod 4. Otherwise `rr` holds. `rr` resets to 0.
- Each grant frees exactly one buffer entry.
- Credit update: `free` <= `free` − `nalloc` + `nissue`.
- If `flush` is high, `free` <= DEPTH instead of the formula, and `rr` is unchanged.
- Underflow/overflow: if the computed value is > DEPTH or < 0, `free` saturates to DEPTH or 0 and `credit_err` <= 1. `credit_err` clears only on `rst`.
- `free_cnt` = `free`.

## Timing
- Allocation and issue grants are combinational from inputs plus registered `free` and `rr`, with zero-cycle latency. Consumers register them.
- Credits from this cycle's issues become allocatable the next cycle. No same-cycle bypass.
- Simultaneous alloc and issue: `free` = 0 with `nissue` = 2 and `nreq` = 1 gives `alloc_stall` = 1; next cycle `free` = 2.
- `stall` blocks issue only. Allocation proceeds.
- `rst` high: all combinational outputs forced to 0 regardless of inputs.
- Reset values: `free` = DEPTH, `rr` = 0, `credit_err` = 0, `free_cnt` = DEPTH, `alloc_stall` = 0, all `newRsSelect` and `outRsSelect` = 0.
- Reset mid-operation: the counter returns to DEPTH on the next edge and pending requests are dropped. Reset has priority over `flush`.

## Test plan
- Reset and fill:
  - `rst` for 2 cycles → `free_cnt` = 32, all outputs 0.
  - Then `alloc_req` = 3'b111 for 10 cycles, no issue → `free_cnt` 32, 29, …, 2.
  - Cycle 11 → `alloc_stall` = 1, `newRsSelect` = 000.
  - Then `alloc_req` = 3'b011 → granted, `free_cnt` = 0.
- Round-robin:
  - `portReady` = 4'b1111, `fu_busy` = 0 → grants {0,1}, then {2,3}, then {0,1}.
  - `rr` sequence 0, 2, 0; `free_cnt` rises by 2 per cycle until 32.
- Busy and stall masking:
  - `portReady` = 1111, `fu_busy` = 4'b0101, `rr` = 0 → grants ports 1 and 3, then `rr` = 0.
  - `stall` = 1 → no grants, `rr` held, while a same-cycle `alloc_req` = 001 is still granted.
- Simultaneous alloc/issue at `free` = 0:
  - `nreq` = 1, grants on ports 0 and 2 → `alloc_stall` = 1; next cycle `free_cnt` = 2.
  - Retry → grant, `free_cnt` = 1.
- Flush:
  - At `free_cnt` = 5, `flush` with `alloc_req` = 111 → grant, `free_cnt` = 32 next cycle.
  - `rst` with `flush` → reset values.
- Error:
  - At `free_cnt` = 32, force `portReady` = 0001 → `free_cnt` stays 32.
  - `credit_err` = 1 and stays 1 until `rst`.
